// File: rtl/sys_ctrl_rx_gen2.sv
// sys_ctrl_rx_gen2 -- second-generation receive-side system controller.
//
// Decodes command frames arriving byte-by-byte from the UART receiver and
// turns them into register-file writes/reads, ALU operations and clock
// enables. Read data and ALU results are handed to the UART transmit path.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   UART_RX_DATA/_VLD   received byte and its one-cycle valid strobe
//   RF_RdData/_VLD      register-file read data and valid
//   ALU_OUT/_VLD        ALU result (2*WIDTH) and valid
//   UART_TX_BUSY        transmitter busy; no send strobe while high
//   ALU_EN, ALU_FUN     ALU start and function (combinational, VLD cycle)
//   CLKG_EN             ALU clock-gate enable (ALU_FUN / ALU_WAIT states)
//   CLKDIV_EN           clock divider enable, 1 after reset
//   RF_WrEn, RF_RdEn    register-file write / read enables
//   RF_Address          register-file address
//   RF_WrData           register-file write data
//   UART_RF_SEND        one-cycle strobe: UART_SEND_RF_DATA is to be sent
//   UART_ALU_SEND       one-cycle strobe: UART_SEND_ALU_DATA is to be sent
//   UART_SEND_RF_DATA   registered RF read data
//   UART_SEND_ALU_DATA  registered ALU result
//   CMD_ERR             one-cycle pulse on bad command, zero count, timeout
//   BUSY                high whenever the controller is not idle
module sys_ctrl_rx_gen2 #(
    parameter int WIDTH    = 8,
    parameter int ADDR     = 4,
    parameter int FUN_W    = 4,
    parameter int OPA_ADDR = 0,
    parameter int OPB_ADDR = 1,
    parameter int TIMEOUT  = 1023
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     UART_RX_DATA,
    input  logic                 UART_RX_VLD,
    input  logic [WIDTH-1:0]     RF_RdData,
    input  logic                 RF_RdData_VLD,
    input  logic [2*WIDTH-1:0]   ALU_OUT,
    input  logic                 ALU_OUT_VLD,
    input  logic                 UART_TX_BUSY,
    output logic                 ALU_EN,
    output logic [FUN_W-1:0]     ALU_FUN,
    output logic                 CLKG_EN,
    output logic                 CLKDIV_EN,
    output logic                 RF_WrEn,
    output logic                 RF_RdEn,
    output logic [ADDR-1:0]      RF_Address,
    output logic [WIDTH-1:0]     RF_WrData,
    output logic                 UART_RF_SEND,
    output logic                 UART_ALU_SEND,
    output logic [WIDTH-1:0]     UART_SEND_RF_DATA,
    output logic [2*WIDTH-1:0]   UART_SEND_ALU_DATA,
    output logic                 CMD_ERR,
    output logic                 BUSY
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [4:0] {
        S_IDLE,
        S_WR_ADDR, S_WR_DATA,
        S_RD_ADDR, S_RD_WAIT, S_RD_TX,
        S_ALU_OPA, S_ALU_OPB, S_ALU_FUN, S_ALU_WAIT,
        S_BW_ADDR, S_BW_CNT, S_BW_DATA,
        S_BR_ADDR, S_BR_CNT, S_BR_WAIT, S_BR_TX
    } state_t;

    state_t                 state_q;
    logic [ADDR-1:0]        addr_q;
    logic [WIDTH-1:0]       cnt_q;
    logic [TW-1:0]          tmo_q;
    logic                   alu_done_q;
    logic                   err_q;
    logic                   clkdiv_q;
    logic [WIDTH-1:0]       rf_data_q;
    logic [2*WIDTH-1:0]     alu_data_q;
    logic                   byte_wait;

    assign CMD_ERR            = err_q;
    assign CLKDIV_EN          = clkdiv_q;
    assign UART_SEND_RF_DATA  = rf_data_q;
    assign UART_SEND_ALU_DATA = alu_data_q;
    assign BUSY               = (state_q != S_IDLE);

    // States that wait for a UART byte; only these run the timeout counter.
    always_comb begin
        byte_wait = 1'b0;
        case (state_q)
            S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_ALU_OPA, S_ALU_OPB, S_ALU_FUN,
            S_BW_ADDR, S_BW_CNT, S_BW_DATA, S_BR_ADDR, S_BR_CNT:
                byte_wait = 1'b1;
            default: byte_wait = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            alu_done_q <= 1'b0;
            err_q      <= 1'b0;
            clkdiv_q   <= 1'b1;
            rf_data_q  <= '0;
            alu_data_q <= '0;
        end else begin
            err_q <= 1'b0;
            tmo_q <= '0;
            case (state_q)
                S_IDLE: if (UART_RX_VLD) begin
                    case (UART_RX_DATA)
                        WIDTH'(8'hAA): state_q <= S_WR_ADDR;
                        WIDTH'(8'hBB): state_q <= S_RD_ADDR;
                        WIDTH'(8'hCC): state_q <= S_ALU_OPA;
                        WIDTH'(8'hDD): state_q <= S_ALU_FUN;
                        WIDTH'(8'hEE): state_q <= S_BW_ADDR;
                        WIDTH'(8'hEF): state_q <= S_BR_ADDR;
                        default:       err_q   <= 1'b1;
                    endcase
                end
                S_WR_ADDR: if (UART_RX_VLD) begin
                    addr_q  <= UART_RX_DATA[ADDR-1:0];
                    state_q <= S_WR_DATA;
                end
                S_WR_DATA: if (UART_RX_VLD) state_q <= S_IDLE;
                S_RD_ADDR: if (UART_RX_VLD) begin
                    addr_q  <= UART_RX_DATA[ADDR-1:0];
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: if (RF_RdData_VLD) begin
                    rf_data_q <= RF_RdData;
                    state_q   <= S_RD_TX;
                end
                S_RD_TX: if (!UART_TX_BUSY) state_q <= S_IDLE;
                S_ALU_OPA: if (UART_RX_VLD) state_q <= S_ALU_OPB;
                S_ALU_OPB: if (UART_RX_VLD) state_q <= S_ALU_FUN;
                S_ALU_FUN: if (UART_RX_VLD) begin
                    alu_done_q <= 1'b0;
                    state_q    <= S_ALU_WAIT;
                end
                // Capture first, then wait for the transmitter; the result is
                // held in alu_data_q for as long as TX stays busy.
                S_ALU_WAIT: begin
                    if (!alu_done_q) begin
                        if (ALU_OUT_VLD) begin
                            alu_data_q <= ALU_OUT;
                            alu_done_q <= 1'b1;
                        end
                    end else if (!UART_TX_BUSY) begin
                        alu_done_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_BW_ADDR: if (UART_RX_VLD) begin
                    addr_q  <= UART_RX_DATA[ADDR-1:0];
                    state_q <= S_BW_CNT;
                end
                S_BW_CNT: if (UART_RX_VLD) begin
                    if (UART_RX_DATA == '0) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= UART_RX_DATA;
                        state_q <= S_BW_DATA;
                    end
                end
                S_BW_DATA: if (UART_RX_VLD) begin
                    addr_q <= addr_q + ADDR'(1);
                    cnt_q  <= cnt_q - WIDTH'(1);
                    if (cnt_q == WIDTH'(1)) state_q <= S_IDLE;
                end
                S_BR_ADDR: if (UART_RX_VLD) begin
                    addr_q  <= UART_RX_DATA[ADDR-1:0];
                    state_q <= S_BR_CNT;
                end
                S_BR_CNT: if (UART_RX_VLD) begin
                    if (UART_RX_DATA == '0) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= UART_RX_DATA;
                        state_q <= S_BR_WAIT;
                    end
                end
                S_BR_WAIT: if (RF_RdData_VLD) begin
                    rf_data_q <= RF_RdData;
                    state_q   <= S_BR_TX;
                end
                S_BR_TX: if (!UART_TX_BUSY) begin
                    if (cnt_q > WIDTH'(1)) begin
                        addr_q  <= addr_q + ADDR'(1);
                        cnt_q   <= cnt_q - WIDTH'(1);
                        state_q <= S_BR_WAIT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Every transition out of a byte-wait state happens on VLD or on
            // expiry, so the default clear above covers "clear on state change".
            // A VLD in the expiry cycle takes the case branch above instead.
            if ((TIMEOUT != 0) && byte_wait && !UART_RX_VLD) begin
                if (tmo_q == TW'(TIMEOUT)) begin
                    err_q   <= 1'b1;
                    state_q <= S_IDLE;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end
        end
    end

    // Mealy outputs: write/ALU strobes appear in the cycle the byte is valid.
    always_comb begin
        RF_WrEn       = 1'b0;
        RF_RdEn       = 1'b0;
        RF_Address    = '0;
        RF_WrData     = '0;
        ALU_EN        = 1'b0;
        ALU_FUN       = '0;
        CLKG_EN       = 1'b0;
        UART_RF_SEND  = 1'b0;
        UART_ALU_SEND = 1'b0;
        case (state_q)
            S_WR_DATA, S_BW_DATA: begin
                RF_Address = addr_q;
                if (UART_RX_VLD) begin
                    RF_WrEn   = 1'b1;
                    RF_WrData = UART_RX_DATA;
                end
            end
            S_ALU_OPA, S_ALU_OPB: begin
                RF_Address = (state_q == S_ALU_OPA) ? ADDR'(OPA_ADDR) : ADDR'(OPB_ADDR);
                if (UART_RX_VLD) begin
                    RF_WrEn   = 1'b1;
                    RF_WrData = UART_RX_DATA;
                end
            end
            S_RD_WAIT, S_BR_WAIT: begin
                RF_RdEn    = 1'b1;
                RF_Address = addr_q;
            end
            S_RD_TX, S_BR_TX: UART_RF_SEND = !UART_TX_BUSY;
            S_ALU_FUN: begin
                CLKG_EN = 1'b1;
                if (UART_RX_VLD) begin
                    ALU_EN  = 1'b1;
                    ALU_FUN = UART_RX_DATA[FUN_W-1:0];
                end
            end
            S_ALU_WAIT: begin
                CLKG_EN       = 1'b1;
                UART_ALU_SEND = alu_done_q && !UART_TX_BUSY;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sys_ctrl_rx_gen2.sv
// Bench for sys_ctrl_rx_gen2: acts as UART RX source, register file and ALU,
// logs DUT transactions and compares them with a frame-level reference model.
module tb_sys_ctrl_rx_gen2;
    localparam int W   = 8;
    localparam int A   = 4;
    localparam int F   = 4;
    localparam int TMO = 20;

    logic CLK = 1'b0;
    logic RST;
    logic [W-1:0]   UART_RX_DATA;
    logic           UART_RX_VLD;
    logic [W-1:0]   RF_RdData;
    logic           RF_RdData_VLD;
    logic [2*W-1:0] ALU_OUT;
    logic           ALU_OUT_VLD;
    logic           UART_TX_BUSY;
    logic           ALU_EN, CLKG_EN, CLKDIV_EN, RF_WrEn, RF_RdEn;
    logic [F-1:0]   ALU_FUN;
    logic [A-1:0]   RF_Address;
    logic [W-1:0]   RF_WrData, UART_SEND_RF_DATA;
    logic           UART_RF_SEND, UART_ALU_SEND, CMD_ERR, BUSY;
    logic [2*W-1:0] UART_SEND_ALU_DATA;

    sys_ctrl_rx_gen2 #(.WIDTH(W), .ADDR(A), .FUN_W(F), .OPA_ADDR(0), .OPB_ADDR(1), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .UART_RX_DATA(UART_RX_DATA), .UART_RX_VLD(UART_RX_VLD),
        .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD), .ALU_OUT(ALU_OUT),
        .ALU_OUT_VLD(ALU_OUT_VLD), .UART_TX_BUSY(UART_TX_BUSY), .ALU_EN(ALU_EN),
        .ALU_FUN(ALU_FUN), .CLKG_EN(CLKG_EN), .CLKDIV_EN(CLKDIV_EN), .RF_WrEn(RF_WrEn),
        .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
        .UART_RF_SEND(UART_RF_SEND), .UART_ALU_SEND(UART_ALU_SEND),
        .UART_SEND_RF_DATA(UART_SEND_RF_DATA), .UART_SEND_ALU_DATA(UART_SEND_ALU_DATA),
        .CMD_ERR(CMD_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int vec = 0;
    int bad = 0;

    // Logs written only by the monitor.
    int obs_wr[$], obs_rd[$], obs_rfs[$], obs_alus[$], obs_fun[$], rd_delay[$];
    int err_cycles = 0, busy_viol = 0, clkg_bad = 0, cyc = 0, last_rdvld = 0;
    // Expectations written only by the main sequence.
    int exp_wr[$], exp_rd[$], exp_rfs[$], exp_alus[$], exp_fun[$];
    int rd_lat = 2, alu_lat = 2, alu_val = 0;
    int b_wr, b_rd, b_rfs, b_alus, b_fun, b_dly, b_err, b_bv, b_cg;

    function automatic int rf_val(input int a);
        return (a * 37 + 'h97) % 256;
    endfunction

    function automatic int qsig(input int q[$], input int from);
        int h = 7;
        for (int i = from; i < q.size(); i++) h = h * 31 + q[i] + 1;
        return h;
    endfunction

    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            if (RF_WrEn) obs_wr.push_back(int'({RF_Address, RF_WrData}));
            if (RF_RdEn && RF_RdData_VLD) begin
                obs_rd.push_back(int'(RF_Address));
                last_rdvld = cyc;
            end
            if (UART_RF_SEND) begin
                obs_rfs.push_back(int'(UART_SEND_RF_DATA));
                rd_delay.push_back(cyc - last_rdvld);
                if (UART_TX_BUSY) busy_viol++;
            end
            if (UART_ALU_SEND) begin
                obs_alus.push_back(int'(UART_SEND_ALU_DATA));
                if (UART_TX_BUSY) busy_viol++;
            end
            if (ALU_EN) begin
                obs_fun.push_back(int'(ALU_FUN));
                if (!CLKG_EN) clkg_bad++;
            end
            if (ALU_OUT_VLD && !CLKG_EN) clkg_bad++;
            if (CMD_ERR) err_cycles++;
        end
    end

    // Register-file and ALU responders with configurable latency.
    initial begin
        int rd_cnt = 0, alu_cnt = 0;
        logic alu_seen;
        RF_RdData = '0; RF_RdData_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
        forever begin
            @(negedge CLK);
            alu_seen = ALU_EN;
            @(posedge CLK); #1;
            if (RF_RdData_VLD) RF_RdData_VLD = 1'b0;
            else if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    RF_RdData = W'(rf_val(int'(RF_Address)));
                    RF_RdData_VLD = 1'b1;
                end
            end else if (RF_RdEn) rd_cnt = rd_lat;
            if (ALU_OUT_VLD) ALU_OUT_VLD = 1'b0;
            else if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    ALU_OUT = (2*W)'(alu_val);
                    ALU_OUT_VLD = 1'b1;
                end
            end else if (alu_seen) alu_cnt = alu_lat;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        tick(gap);
        UART_RX_DATA = b;
        UART_RX_VLD  = 1'b1;
        tick(1);
        UART_RX_VLD  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 300) begin tick(1); n++; end
        vec++;
        if (BUSY) begin
            bad++;
            $display("FAIL idle_wait: BUSY still %0b after %0d cycles, want 0", BUSY, n);
        end
        tick(2);
    endtask

    task automatic snap();
        b_wr = obs_wr.size(); b_rd = obs_rd.size(); b_rfs = obs_rfs.size();
        b_alus = obs_alus.size(); b_fun = obs_fun.size(); b_dly = rd_delay.size();
        b_err = err_cycles; b_bv = busy_viol; b_cg = clkg_bad;
        exp_wr.delete(); exp_rd.delete(); exp_rfs.delete(); exp_alus.delete(); exp_fun.delete();
    endtask

    task automatic test_reset();
        RST = 1'b1; UART_RX_DATA = '0; UART_RX_VLD = 1'b0; UART_TX_BUSY = 1'b0;
        tick(3);
        RST = 1'b0;
        vec++;
        if ({ALU_EN, ALU_FUN, CLKG_EN, RF_WrEn, RF_RdEn, RF_Address, RF_WrData, UART_RF_SEND,
             UART_ALU_SEND, UART_SEND_RF_DATA, UART_SEND_ALU_DATA, CMD_ERR, BUSY} !== '0) begin
            bad++;
            $display("FAIL reset_outs: outputs not all zero (BUSY=%b CMD_ERR=%b rf=%h alu=%h)",
                     BUSY, CMD_ERR, UART_SEND_RF_DATA, UART_SEND_ALU_DATA);
        end
        vec++;
        if (CLKDIV_EN !== 1'b1) begin
            bad++;
            $display("FAIL reset_clkdiv: got %b want 1", CLKDIV_EN);
        end
    endtask

    task automatic test_write();
        snap();
        send_byte(8'hAA, 5); send_byte(8'h05, 5); send_byte(8'h3C, 5);
        vec++;
        if (BUSY !== 1'b0) begin bad++; $display("FAIL write_busy: got %b want 0", BUSY); end
        tick(2);
        exp_wr.push_back('h53C);
        vec++;
        if (obs_wr.size() - b_wr !== 1 || qsig(obs_wr, b_wr) !== qsig(exp_wr, 0)) begin
            bad++;
            $display("FAIL write_log: got n=%0d sig=%h want n=1 sig=%h", obs_wr.size() - b_wr,
                     qsig(obs_wr, b_wr), qsig(exp_wr, 0));
        end
        vec++;
        if (err_cycles - b_err !== 0) begin bad++; $display("FAIL write_err: got %0d want 0", err_cycles - b_err); end
    endtask

    task automatic test_read();
        snap();
        rd_lat = 2;
        UART_TX_BUSY = 1'b1;
        send_byte(8'hBB, 0); send_byte(8'h07, 0);
        tick(10);
        vec++;
        if (obs_rfs.size() - b_rfs !== 0 || UART_SEND_RF_DATA !== 8'h9A) begin
            bad++;
            $display("FAIL read_hold: sends=%0d data=%h want sends=0 data=9a", obs_rfs.size() - b_rfs, UART_SEND_RF_DATA);
        end
        UART_TX_BUSY = 1'b0;
        wait_idle();
        exp_rd.push_back(7); exp_rfs.push_back('h9A);
        vec++;
        if (qsig(obs_rd, b_rd) !== qsig(exp_rd, 0) || qsig(obs_rfs, b_rfs) !== qsig(exp_rfs, 0)) begin
            bad++;
            $display("FAIL read_log: rd n=%0d send n=%0d want 1 read @7 and 1 send of 9a",
                     obs_rd.size() - b_rd, obs_rfs.size() - b_rfs);
        end
        vec++;
        if (busy_viol - b_bv !== 0) begin bad++; $display("FAIL read_busy_send: got %0d want 0", busy_viol - b_bv); end
    endtask

    task automatic test_alu();
        snap();
        alu_lat = 2; alu_val = 'h0046;
        send_byte(8'hCC, 1); send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'h02, 1);
        wait_idle();
        exp_wr.push_back('h012); exp_wr.push_back('h134); exp_fun.push_back(2); exp_alus.push_back('h46);
        vec++;
        if (obs_wr.size() - b_wr !== 2 || qsig(obs_wr, b_wr) !== qsig(exp_wr, 0)) begin
            bad++;
            $display("FAIL alu_opwr: got n=%0d sig=%h want n=2 sig=%h", obs_wr.size() - b_wr,
                     qsig(obs_wr, b_wr), qsig(exp_wr, 0));
        end
        vec++;
        if (qsig(obs_fun, b_fun) !== qsig(exp_fun, 0) || clkg_bad - b_cg !== 0) begin
            bad++;
            $display("FAIL alu_en: fun n=%0d clkg_bad=%0d want 1 start fun=2 and clkg_bad=0",
                     obs_fun.size() - b_fun, clkg_bad - b_cg);
        end
        vec++;
        if (qsig(obs_alus, b_alus) !== qsig(exp_alus, 0) || UART_SEND_ALU_DATA !== 16'h0046) begin
            bad++;
            $display("FAIL alu_send: n=%0d data=%h want 1 send of 0046", obs_alus.size() - b_alus, UART_SEND_ALU_DATA);
        end
    endtask

    task automatic test_burst();
        snap();
        send_byte(8'hEE, 0); send_byte(8'h0E, 1); send_byte(8'h03, 0);
        send_byte(8'h11, 2); send_byte(8'h22, 0); send_byte(8'h33, 3);
        wait_idle();
        exp_wr.push_back('hE11); exp_wr.push_back('hF22); exp_wr.push_back('h033);
        vec++;
        if (obs_wr.size() - b_wr !== 3 || qsig(obs_wr, b_wr) !== qsig(exp_wr, 0)) begin
            bad++;
            $display("FAIL burst_wr: got n=%0d sig=%h want n=3 sig=%h", obs_wr.size() - b_wr,
                     qsig(obs_wr, b_wr), qsig(exp_wr, 0));
        end
        rd_lat = 3;
        send_byte(8'hEF, 0); send_byte(8'h0F, 0); send_byte(8'h02, 0);
        wait_idle();
        exp_rd.push_back(15); exp_rd.push_back(0);
        exp_rfs.push_back(rf_val(15)); exp_rfs.push_back(rf_val(0));
        vec++;
        if (obs_rd.size() - b_rd !== 2 || qsig(obs_rd, b_rd) !== qsig(exp_rd, 0) ||
            qsig(obs_rfs, b_rfs) !== qsig(exp_rfs, 0)) begin
            bad++;
            $display("FAIL burst_rd: reads=%0d sends=%0d want reads @15,@0 and 2 sends",
                     obs_rd.size() - b_rd, obs_rfs.size() - b_rfs);
        end
        for (int i = b_dly; i < rd_delay.size(); i++) begin
            vec++;
            if (rd_delay[i] !== 1) begin
                bad++;
                $display("FAIL send_latency: got %0d cycles want 1", rd_delay[i]);
            end
        end
    endtask

    task automatic test_errors();
        snap();
        send_byte(8'h55, 0);
        tick(3);
        vec++;
        if (err_cycles - b_err !== 1 || BUSY !== 1'b0) begin
            bad++; $display("FAIL bad_cmd: err=%0d busy=%b want 1 and 0", err_cycles - b_err, BUSY);
        end
        send_byte(8'hEE, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
        tick(3);
        vec++;
        if (err_cycles - b_err !== 2 || obs_wr.size() - b_wr !== 0 || BUSY !== 1'b0) begin
            bad++; $display("FAIL zero_cnt: err=%0d wr=%0d busy=%b want 2, 0, 0", err_cycles - b_err, obs_wr.size() - b_wr, BUSY);
        end
        send_byte(8'hAA, 0); send_byte(8'h03, 0);
        tick(TMO);
        vec++;
        if (BUSY !== 1'b1 || err_cycles - b_err !== 2) begin
            bad++; $display("FAIL tmo_early: busy=%b err=%0d want 1 and 2", BUSY, err_cycles - b_err);
        end
        tick(2);
        vec++;
        if (BUSY !== 1'b0 || err_cycles - b_err !== 3 || obs_wr.size() - b_wr !== 0) begin
            bad++; $display("FAIL tmo_expire: busy=%b err=%0d wr=%0d want 0, 3, 0", BUSY, err_cycles - b_err, obs_wr.size() - b_wr);
        end
        send_byte(8'hAA, 0); send_byte(8'h03, 0); send_byte(8'h77, TMO);
        tick(3);
        exp_wr.push_back('h377);
        vec++;
        if (err_cycles - b_err !== 3 || qsig(obs_wr, b_wr) !== qsig(exp_wr, 0) || BUSY !== 1'b0) begin
            bad++; $display("FAIL tmo_edge_vld: err=%0d wr=%0d busy=%b want 3, 1 write 377, 0", err_cycles - b_err, obs_wr.size() - b_wr, BUSY);
        end
    endtask

    task automatic test_reset_mid();
        snap();
        send_byte(8'hEE, 0); send_byte(8'h04, 0); send_byte(8'h03, 0); send_byte(8'hA1, 0);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        vec++;
        if ({BUSY, CMD_ERR, RF_WrEn, RF_Address, UART_SEND_RF_DATA, UART_SEND_ALU_DATA} !== '0 || CLKDIV_EN !== 1'b1) begin
            bad++; $display("FAIL midreset_outs: busy=%b err=%b clkdiv=%b want 0,0,1", BUSY, CMD_ERR, CLKDIV_EN);
        end
        tick(8);
        send_byte(8'hAA, 0); send_byte(8'h09, 0); send_byte(8'h5C, 0);
        tick(3);
        exp_wr.push_back('h4A1); exp_wr.push_back('h95C);
        vec++;
        if (obs_wr.size() - b_wr !== 2 || qsig(obs_wr, b_wr) !== qsig(exp_wr, 0) || err_cycles - b_err !== 0) begin
            bad++; $display("FAIL midreset_log: wr=%0d err=%0d want 2 writes (4a1,95c), 0 errors", obs_wr.size() - b_wr, err_cycles - b_err);
        end
    endtask

    task automatic test_random();
        logic [7:0] fr[$];
        int kind, a, c, v, e_err;
        snap();
        e_err = 0;
        for (int n = 0; n < 40; n++) begin
            fr.delete();
            kind = $urandom_range(0, 6);
            rd_lat = $urandom_range(1, 3); alu_lat = $urandom_range(1, 3); alu_val = $urandom_range(0, 65535);
            a = $urandom_range(0, 255);
            case (kind)
                0: begin
                    v = $urandom_range(0, 255);
                    fr.push_back(8'hAA); fr.push_back(8'(a)); fr.push_back(8'(v));
                    exp_wr.push_back((a % 16) * 256 + v);
                end
                1: begin
                    fr.push_back(8'hBB); fr.push_back(8'(a));
                    exp_rd.push_back(a % 16); exp_rfs.push_back(rf_val(a % 16));
                end
                2: begin
                    v = $urandom_range(0, 255); c = $urandom_range(0, 255);
                    fr.push_back(8'hCC); fr.push_back(8'(a)); fr.push_back(8'(v)); fr.push_back(8'(c));
                    exp_wr.push_back(a); exp_wr.push_back(256 + v);
                    exp_fun.push_back(c % 16); exp_alus.push_back(alu_val);
                end
                3: begin
                    fr.push_back(8'hDD); fr.push_back(8'(a));
                    exp_fun.push_back(a % 16); exp_alus.push_back(alu_val);
                end
                4: begin
                    c = $urandom_range(0, 4);
                    fr.push_back(8'hEE); fr.push_back(8'(a)); fr.push_back(8'(c));
                    if (c == 0) e_err++;
                    for (int i = 0; i < c; i++) begin
                        v = $urandom_range(0, 255);
                        fr.push_back(8'(v));
                        exp_wr.push_back(((a + i) % 16) * 256 + v);
                    end
                end
                5: begin
                    c = $urandom_range(0, 3);
                    fr.push_back(8'hEF); fr.push_back(8'(a)); fr.push_back(8'(c));
                    if (c == 0) e_err++;
                    for (int i = 0; i < c; i++) begin
                        exp_rd.push_back((a + i) % 16); exp_rfs.push_back(rf_val((a + i) % 16));
                    end
                end
                default: begin
                    do v = $urandom_range(0, 255);
                    while (v == 'hAA || v == 'hBB || v == 'hCC || v == 'hDD || v == 'hEE || v == 'hEF);
                    fr.push_back(8'(v));
                    e_err++;
                end
            endcase
            foreach (fr[i]) send_byte(fr[i], $urandom_range(0, 3));
            wait_idle();
        end
        vec++;
        if (obs_wr.size() - b_wr !== exp_wr.size() || qsig(obs_wr, b_wr) !== qsig(exp_wr, 0)) begin
            bad++; $display("FAIL rand_wr: got n=%0d sig=%h want n=%0d sig=%h", obs_wr.size() - b_wr,
                            qsig(obs_wr, b_wr), exp_wr.size(), qsig(exp_wr, 0));
        end
        vec++;
        if (obs_rd.size() - b_rd !== exp_rd.size() || qsig(obs_rd, b_rd) !== qsig(exp_rd, 0)) begin
            bad++; $display("FAIL rand_rd: got n=%0d want n=%0d", obs_rd.size() - b_rd, exp_rd.size());
        end
        vec++;
        if (obs_rfs.size() - b_rfs !== exp_rfs.size() || qsig(obs_rfs, b_rfs) !== qsig(exp_rfs, 0)) begin
            bad++; $display("FAIL rand_rfsend: got n=%0d want n=%0d", obs_rfs.size() - b_rfs, exp_rfs.size());
        end
        vec++;
        if (obs_fun.size() - b_fun !== exp_fun.size() || qsig(obs_fun, b_fun) !== qsig(exp_fun, 0) ||
            qsig(obs_alus, b_alus) !== qsig(exp_alus, 0)) begin
            bad++; $display("FAIL rand_alu: starts=%0d sends=%0d want %0d, %0d", obs_fun.size() - b_fun,
                            obs_alus.size() - b_alus, exp_fun.size(), exp_alus.size());
        end
        vec++;
        if (err_cycles - b_err !== e_err || busy_viol - b_bv !== 0 || clkg_bad - b_cg !== 0) begin
            bad++; $display("FAIL rand_err: err=%0d bv=%0d cg=%0d want %0d, 0, 0", err_cycles - b_err,
                            busy_viol - b_bv, clkg_bad - b_cg, e_err);
        end
        for (int i = b_dly; i < rd_delay.size(); i++) begin
            vec++;
            if (rd_delay[i] !== 1) begin bad++; $display("FAIL rand_latency: got %0d want 1", rd_delay[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alu();
        test_burst();
        test_errors();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
